// File: rtl/psum_collector_pkg.sv
// Shared definitions for the partial-sum collector.
// Provides the DATA_SIZE default, default column count and address width, and the
// collector FSM state encoding (IDLE=0, COLLECT=1, DRAIN=2, DONE=3).
// Optional feature macro used by psum_collector: PSUM_RELU_EN.
`ifndef DATA_SIZE
`define DATA_SIZE 16
`endif

package psum_collector_pkg;

  localparam int unsigned COLS_DEFAULT   = 4;
  localparam int unsigned ADDR_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StDrain   = 2'd2,
    StDone    = 2'd3
  } state_e;

endpackage

// File: rtl/psum_row_fifo.sv
// First-word-fall-through FIFO for aligned partial-sum rows.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data (ignored when full unless popping this cycle)
//   push_data    row to write
//   pop          consume head (ignored when empty)
//   head         current head entry, valid while !empty
//   full, empty  occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module psum_row_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PtrW + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO can still accept a row when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/psum_collector.sv
// Collects skewed column partial sums from the bottom row of the systolic array,
// deskews them into whole rows, buffers them in a small FIFO and writes them out
// over a valid/ready interface with an incrementing row address.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle pulse, begins a tile (ignored while busy)
//   num_rows, base_addr tile row count (0 means 1) and first address, sampled on start
//   in_valid            column-0 valid tag; in_psum carries all columns, skewed
//   out_valid/out_ready row handshake; out_data is the aligned row, out_addr its address
//   busy, done          tile in progress / one-cycle completion pulse
//   overflow            sticky, a row was dropped on a full FIFO; cleared on start
// Optional macro PSUM_RELU_EN: negative lanes are driven as 0 on out_data.
module psum_collector
  import psum_collector_pkg::*;
#(
  parameter int unsigned COLS       = COLS_DEFAULT,
  parameter int unsigned DATA_W     = `DATA_SIZE,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = ADDR_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        num_rows,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic                     in_valid,
  input  logic [COLS*DATA_W-1:0]   in_psum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COLS*DATA_W-1:0]   out_data,
  output logic [ADDR_W-1:0]        out_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int unsigned RowW = COLS * DATA_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] num_rows_q, num_rows_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] rows_in_q, rows_in_d;
  logic [ADDR_W-1:0] rows_out_q, rows_out_d;
  logic              ovf_q, ovf_d;

  logic [COLS-2:0]   vld_q;
  logic              row_valid;
  logic [RowW-1:0]   row_data;
  logic [RowW-1:0]   fifo_head;
  logic              fifo_full, fifo_empty, push, pop;

  // Deskew: column j waits COLS-1-j cycles so every column lines up with column COLS-1.
  for (genvar j = 0; j < COLS; j++) begin : g_col
    localparam int unsigned D = COLS - 1 - j;
    logic [DATA_W-1:0] lane_in;
    assign lane_in = in_psum[j*DATA_W +: DATA_W];
    if (D == 0) begin : g_thru
      assign row_data[j*DATA_W +: DATA_W] = lane_in;
    end else begin : g_dly
      logic [DATA_W-1:0] sr_q [D];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned k = 0; k < D; k++) sr_q[k] <= '0;
        end else begin
          sr_q[0] <= lane_in;
          for (int unsigned k = 1; k < D; k++) sr_q[k] <= sr_q[k-1];
        end
      end
      assign row_data[j*DATA_W +: DATA_W] = sr_q[D-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= (vld_q << 1) | (COLS - 1)'(in_valid);
  end
  assign row_valid = vld_q[COLS-2];

  psum_row_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RowW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (row_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_addr  = base_q + rows_out_q;
  assign busy      = (state_q == StCollect) || (state_q == StDrain);
  assign done      = (state_q == StDone);
  assign overflow  = ovf_q;

`ifdef PSUM_RELU_EN
  for (genvar j = 0; j < COLS; j++) begin : g_relu
    logic [DATA_W-1:0] lane;
    assign lane = fifo_head[j*DATA_W +: DATA_W];
    assign out_data[j*DATA_W +: DATA_W] = lane[DATA_W-1] ? '0 : lane;
  end
`else
  assign out_data = fifo_head;
`endif

  always_comb begin
    state_d    = state_q;
    num_rows_d = num_rows_q;
    base_d     = base_q;
    rows_in_d  = rows_in_q;
    rows_out_d = rows_out_q;
    ovf_d      = ovf_q;
    push       = 1'b0;

    if (pop) rows_out_d = rows_out_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StCollect;
          num_rows_d = (num_rows == '0) ? ADDR_W'(1) : num_rows;
          base_d     = base_addr;
          rows_in_d  = '0;
          rows_out_d = '0;
          ovf_d      = 1'b0;
        end
      end
      StCollect: begin
        if (rows_in_q == num_rows_q) begin
          state_d = StDrain;
        end else if (row_valid) begin
          // A dropped row still counts so the tile always terminates.
          rows_in_d = rows_in_q + 1'b1;
          if (fifo_full && !pop) ovf_d = 1'b1;
          else                   push  = 1'b1;
        end
      end
      StDrain: begin
        // Dropped rows never reach the FIFO, so completion means the FIFO is empty.
        if (fifo_empty) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      num_rows_q <= '0;
      base_q     <= '0;
      rows_in_q  <= '0;
      rows_out_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_rows_q <= num_rows_d;
      base_q     <= base_d;
      rows_in_q  <= rows_in_d;
      rows_out_q <= rows_out_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_psum_collector.sv
// Self-checking bench for psum_collector. A queue-based model predicts each
// cycle's out_valid/out_data/out_addr/overflow from the row arrival times,
// the ready pattern and the FIFO capacity.
module tb_psum_collector;

  localparam int COLS  = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 8;
  localparam int RW    = COLS * DW;
  localparam int MAXC  = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] num_rows = '0;
  logic [AW-1:0] base_addr = '0;
  logic          in_valid = 1'b0;
  logic [RW-1:0] in_psum = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [RW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          busy, done, overflow;

  psum_collector #(
    .COLS       (COLS),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .ADDR_W     (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_rows  (num_rows),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_psum   (in_psum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Stimulus schedule and model state
  logic [DW-1:0] sch_psum [MAXC][COLS];
  logic          sch_vld  [MAXC];
  int            push_at  [MAXC];
  logic [RW-1:0] tile_rows [16];
  logic [RW-1:0] mq [$];
  bit            m_ovf = 1'b0;
  int            m_popped = 0;
  int            first_ov;
  logic [RW-1:0] first_data;

  function automatic logic [RW-1:0] exp_row(input logic [RW-1:0] r);
    logic [RW-1:0] o;
    o = r;
`ifdef PSUM_RELU_EN
    for (int j = 0; j < COLS; j++)
      if (r[j*DW + DW - 1]) o[j*DW +: DW] = '0;
`endif
    return o;
  endfunction

  // Runs one tile: start at cycle 0, rows' column-0 valids from cycle 1 with random gaps.
  // rmode: 0 ready always, 1 random ready, 2 ready low for cycles [rs, rs+rl).
  // abort_cyc >= 0 pulls reset at that cycle and checks the immediate clear.
  task automatic run_tile(input int n, input int base, input int nfeed, input int gap_max,
                          input int rmode, input int rs, input int rl, input int abort_cyc);
    int nexp, c, last, cyc, done_cnt, done_cyc, last_pop_cyc;
    bit mv, rdy, pop, push;
    nexp = (n == 0) ? 1 : n;
    for (int k = 0; k < MAXC; k++) begin
      sch_vld[k] = 1'b0;
      push_at[k] = -1;
      for (int j = 0; j < COLS; j++) sch_psum[k][j] = DW'($urandom);
    end
    c = 1;
    last = 1;
    for (int r = 0; r < nfeed; r++) begin
      sch_vld[c] = 1'b1;
      for (int j = 0; j < COLS; j++) sch_psum[c+j][j] = tile_rows[r][j*DW +: DW];
      if (r < nexp) push_at[c+COLS-1] = r;
      last = c;
      c += 1 + int'($urandom_range(gap_max, 0));
    end
    cyc = 0; done_cnt = 0; done_cyc = -1; last_pop_cyc = -1; first_ov = -1;
    forever begin
      @(posedge clk); #1;
      start     = (cyc == 0);
      num_rows  = AW'(n);
      base_addr = AW'(base);
      in_valid  = sch_vld[cyc];
      for (int j = 0; j < COLS; j++) in_psum[j*DW +: DW] = sch_psum[cyc][j];
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(1, 0));
        default: rdy = !(cyc >= rs && cyc < rs + rl);
      endcase
      out_ready = rdy;
      if (cyc == abort_cyc) begin
        n_checks++;
        if (busy !== 1'b1) $display("FAIL pre_reset_busy got %b exp 1", busy);
        else n_pass++;
        n_checks++;
        if (overflow !== m_ovf) $display("FAIL pre_reset_ovf got %b exp %b", overflow, m_ovf);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, busy, done, overflow} !== 4'b0)
          $display("FAIL reset_clear got v%b b%b d%b o%b exp all 0",
                   out_valid, busy, done, overflow);
        else n_pass++;
        mq.delete();
        m_ovf = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        return;
      end
      @(negedge clk);
      mv = (mq.size() > 0);
      n_checks++;
      if (out_valid !== mv) $display("FAIL out_valid cyc %0d got %b exp %b", cyc, out_valid, mv);
      else n_pass++;
      if (mv) begin
        n_checks++;
        if (out_data !== exp_row(mq[0]))
          $display("FAIL out_data cyc %0d got %h exp %h", cyc, out_data, exp_row(mq[0]));
        else n_pass++;
        n_checks++;
        if (out_addr !== AW'(base + m_popped))
          $display("FAIL out_addr cyc %0d got %h exp %h", cyc, out_addr, AW'(base + m_popped));
        else n_pass++;
      end
      n_checks++;
      if (overflow !== m_ovf) $display("FAIL overflow cyc %0d got %b exp %b", cyc, overflow, m_ovf);
      else n_pass++;
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (out_valid === 1'b1 && first_ov < 0) begin first_ov = cyc; first_data = out_data; end
      // Model update for the coming clock edge
      pop = mv && rdy;
      if (cyc == 0) begin m_ovf = 1'b0; m_popped = 0; end
      push = 1'b0;
      if (push_at[cyc] >= 0) begin
        if (mq.size() < DEPTH || pop) push = 1'b1;
        else m_ovf = 1'b1;
      end
      if (pop) begin void'(mq.pop_front()); m_popped++; last_pop_cyc = cyc; end
      if (push) mq.push_back(tile_rows[push_at[cyc]]);
      cyc++;
      if (done_cnt > 0 && cyc > last + COLS + 1 && cyc > done_cyc + 2) break;
      if (cyc >= MAXC - COLS) begin
        n_checks++;
        $display("FAIL tile_timeout got no completion after %0d cycles exp done", cyc);
        break;
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (done_cnt !== 1) $display("FAIL done_count got %0d exp 1", done_cnt);
    else n_pass++;
    n_checks++;
    if (!(done_cyc > last_pop_cyc)) $display("FAIL done_order got cyc %0d exp > %0d", done_cyc,
                                             last_pop_cyc);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL busy_end got %b exp 0", busy);
    else n_pass++;
  endtask

  task automatic fill_random(input int cnt);
    for (int r = 0; r < cnt; r++) tile_rows[r] = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({out_valid, busy, done, overflow} !== 4'b0)
      $display("FAIL reset_flags got v%b b%b d%b o%b exp all 0", out_valid, busy, done, overflow);
    else n_pass++;
    n_checks++;
    if (out_data !== '0) $display("FAIL reset_data got %h exp 0", out_data);
    else n_pass++;
    n_checks++;
    if (out_addr !== '0) $display("FAIL reset_addr got %h exp 0", out_addr);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    tile_rows[0] = {16'd4, 16'd3, 16'd2, 16'd1};
    tile_rows[1] = {16'd8, 16'd7, 16'd6, 16'd5};
    tile_rows[2] = {16'd12, 16'd11, 16'd10, 16'd9};
    run_tile(3, 'h10, 3, 0, 0, 0, 0, -1);
    // First column-0 valid is at cycle 1
    n_checks++;
    if (first_ov - 1 !== COLS) $display("FAIL latency got %0d exp %0d", first_ov - 1, COLS);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    fill_random(5);
    run_tile(5, $urandom_range(255, 0), 5, 0, 1, 0, 0, -1);
  endtask

  task automatic test_backpressure();
    fill_random(4);
    run_tile(4, 'h40, 4, 0, 2, 5, 10, -1);
  endtask

  task automatic test_overflow();
    fill_random(6);
    run_tile(6, 'h20, 6, 0, 2, 0, 40, -1);
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL overflow_sticky got %b exp 1", overflow);
    else n_pass++;
    // Next tile must clear the sticky flag at start
    fill_random(2);
    run_tile(2, 'h30, 2, 1, 0, 0, 0, -1);
  endtask

  task automatic test_wrap();
    fill_random(3);
    run_tile(3, 'hFE, 3, 1, 0, 0, 0, -1);
  endtask

  task automatic test_reset_mid_tile();
    fill_random(6);
    run_tile(6, 'h50, 6, 0, 2, 0, 100, 20);
    fill_random(3);
    run_tile(3, 'h60, 3, 0, 0, 0, 0, -1);
  endtask

  task automatic test_relu_row();
    logic [RW-1:0] want;
    tile_rows[0] = {16'd3, 16'h8000, 16'd7, 16'hFFFB};
`ifdef PSUM_RELU_EN
    want = {16'd3, 16'd0, 16'd7, 16'd0};
`else
    want = {16'd3, 16'h8000, 16'd7, 16'hFFFB};
`endif
    run_tile(1, 'h70, 1, 0, 0, 0, 0, -1);
    n_checks++;
    if (first_data !== want) $display("FAIL relu_row got %h exp %h", first_data, want);
    else n_pass++;
  endtask

  task automatic test_random();
    int n;
    for (int t = 0; t < 6; t++) begin
      n = int'($urandom_range(8, 0));
      fill_random(11);
      run_tile(n, $urandom_range(255, 0), ((n == 0) ? 1 : n) + int'($urandom_range(2, 0)),
               2, 1, 0, 0, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_wrap();
    test_reset_mid_tile();
    test_relu_row();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Sits below the bottom row of the systolic PE array and is the consumer of the array's column partial-sum outputs.
- Column j result for output row r arrives skewed at cycle t0+r+j; the block deskews the columns with per-column delay lines and packs each aligned row into a small FIFO.
- Rows are written to the global output buffer through a valid/ready interface with an incrementing row address.
- Reports completion when all expected rows have been accepted downstream.

Parameters:
- COLS, 4, number of array columns (≥2).
- DATA_W, `DATA_SIZE (16), width of one partial sum.
- FIFO_DEPTH, 4, aligned-row FIFO entries (power of 2).
- ADDR_W, 8, output row address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: begin collecting a tile.
- num_rows  in  ADDR_W  rows expected in this tile (sampled on start; 0 treated as 1).
- base_addr  in  ADDR_W  first write address (sampled on start).
- in_valid  in  1  column-0 result valid this cycle (unskewed tag from array controller).
- in_psum  in  COLS*DATA_W  bottom-row out_down bus; column j at bits [j*DATA_W +: DATA_W].
- out_valid  out  1  aligned row available.
- out_ready  in  1  buffer accepts row.
- out_data  out  COLS*DATA_W  aligned row, column j in same slice as input.
- out_addr  out  ADDR_W  write address for out_data.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after last row handshake.
- overflow  out  1  sticky: a row arrived with FIFO full; cleared by next accepted start.

Behaviour:
- Reset: all outputs 0, FSM IDLE, FIFO empty, delay lines 0, counters 0.
- Deskew:
  - Column j is delayed by COLS-1-j registers (column COLS-1 passes straight through).
  - in_valid is delayed by COLS-1 registers to form row_valid.
  - Row r is therefore aligned COLS-1 cycles after its column-0 valid.
  - Delay lines shift every cycle regardless of FSM state.
- FSM:
  - IDLE: start → COLLECT; latch num_rows, base_addr; clear rows_in, rows_out, overflow; busy=1.
  - COLLECT: each row_valid pushes the aligned row if FIFO not full and rows_in<num_rows; rows_in++. When rows_in reaches num_rows → DRAIN.
  - DRAIN: pop continues; when rows_out==num_rows → DONE.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- row_valid handling outside COLLECT:
  - In IDLE, DRAIN or DONE, and when rows_in==num_rows, row_valid is ignored (no push, no overflow).
  - row_valid with FIFO full in COLLECT: row dropped, overflow=1, rows_in still increments so the tile terminates.
- Output handshake:
  - out_valid = FIFO not empty; out_data = FIFO head (first-word-fall-through); out_addr = base_addr+rows_out, wraps mod 2^ADDR_W.
  - Pop on out_valid&&out_ready; rows_out++.
  - out_data and out_addr hold stable while out_valid&&!out_ready.
  - Push and pop in the same cycle with FIFO full is legal: count unchanged, no overflow.
- start while busy: ignored.
- Latency: column-0 valid at cycle t → out_valid at t+COLS (COLS-1 deskew plus 1 FIFO write), given an empty FIFO.
- Arithmetic: no arithmetic on data except the optional clamp; address addition is unsigned and truncated to ADDR_W.
- rst_n deassertion mid-tile: everything returns to reset values immediately; no done pulse.

Optional Feature:
- Macro: PSUM_RELU_EN.
- Defined: each DATA_W lane is treated as signed two's complement at the FIFO output; negative lanes are driven as 0 on out_data. FIFO contents are unchanged.
- Undefined: out_data is the raw FIFO head.
- Timing and handshake are identical either way.

Decomposition:
- Shared package/header (extends define.v): `DATA_SIZE, COLS default, FSM state encodings (IDLE=0, COLLECT=1, DRAIN=2, DONE=3), ADDR_W default.
- Sub-module: psum_row_fifo (parameterised DEPTH, WIDTH; FWFT, full/empty, simultaneous push/pop).
- Deskew delay lines and FSM stay in psum_collector.

Test Plan:
- Basic: COLS=4, num_rows=3, base_addr=0x10; feed skewed rows {1,2,3,4}, {5,6,7,8}, {9,10,11,12} with out_ready=1 → three rows at addr 0x10, 0x11, 0x12, correctly deskewed; first out_valid 4 cycles after first in_valid; done pulses once.
- Backpressure: out_ready=0 for 10 cycles during a 4-row tile, FIFO_DEPTH=4 → out_data/out_addr stable while stalled, no overflow, all 4 rows delivered in order.
- Overflow: out_ready=0, 6 rows, FIFO_DEPTH=4 → rows 5 and 6 dropped, overflow=1 sticky; after out_ready=1, 4 rows drain and done pulses; next start clears overflow.
- Address wrap: base_addr=0xFE, num_rows=3 → addresses 0xFE, 0xFF, 0x00.
- Reset mid-tile: rst_n low during DRAIN → out_valid, busy, done, overflow = 0 at once; a new start works normally.
- PSUM_RELU_EN defined: row {-5, 7, 0x8000, 3} (DATA_W=16) → out_data {0, 7, 0, 3}; undefined → raw values.
